// File: rtl/image_load_ctrl.sv
// Streams one RGB888 image into a slot of shared frame memory through a one-entry holding register.
// Optional idle-byte abort is built when LOAD_TIMEOUT_EN is defined.
module image_load_ctrl #(
   parameter int IMG_WIDTH       = 320,
   parameter int IMG_HEIGHT      = 240,
   parameter int BYTES_PER_PIXEL = 3,
   parameter int NUM_IMAGES      = 16,
   parameter int TIMEOUT_CYCLES  = 1000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [3:0]  load_index,
   input  logic [7:0]  byte_in,
   input  logic        byte_valid,
   output logic        byte_ready,
   output logic        mem_req,
   input  logic        mem_gnt,
   output logic [21:0] mem_addr,
   output logic [7:0]  mem_wdata,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [17:0] byte_count
);

   localparam int BUFFER_SIZE = IMG_WIDTH * IMG_HEIGHT * BYTES_PER_PIXEL;

   typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

   state_t      state_q, state_d;
   logic        hold_q, hold_d;
   logic [7:0]  wdata_q, wdata_d;
   logic [21:0] addr_q, addr_d;
   logic [21:0] base_q, base_d;
   logic [17:0] count_q, count_d;
   logic [17:0] acc_q, acc_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        error_q, error_d;
   logic        write_done;
   logic        capture;

`ifdef LOAD_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TO_W-1:0] to_q, to_d;
`endif

   assign byte_ready = (state_q == LOAD) && (!hold_q || mem_gnt) && (acc_q < 18'(BUFFER_SIZE));
   assign write_done = hold_q && mem_gnt;
   assign capture    = byte_valid && byte_ready;

   assign mem_req    = hold_q;
   assign mem_addr   = addr_q;
   assign mem_wdata  = wdata_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign error      = error_q;
   assign byte_count = count_q;

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      wdata_d = wdata_q;
      addr_d  = addr_q;
      base_d  = base_q;
      count_d = count_q;
      acc_d   = acc_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      error_d = error_q;
`ifdef LOAD_TIMEOUT_EN
      to_d    = to_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               if (32'(load_index) < NUM_IMAGES) begin
                  state_d = LOAD;
                  busy_d  = 1'b1;
                  error_d = 1'b0;
                  count_d = '0;
                  acc_d   = '0;
                  base_d  = 22'(load_index) * 22'(BUFFER_SIZE);
`ifdef LOAD_TIMEOUT_EN
                  to_d    = '0;
`endif
               end else begin
                  error_d = 1'b1;
               end
            end
         end
         LOAD: begin
            if (write_done) begin
               hold_d  = 1'b0;
               count_d = count_q + 18'd1;
            end
            // A capture in the same cycle as a completion refills the register, keeping one byte per cycle.
            if (capture) begin
               hold_d  = 1'b1;
               wdata_d = byte_in;
               addr_d  = base_q + 22'(acc_q);
               acc_d   = acc_q + 18'd1;
            end
            if (write_done && (count_q == 18'(BUFFER_SIZE - 1))) begin
               state_d = DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end
`ifdef LOAD_TIMEOUT_EN
            else if (capture) begin
               to_d = '0;
            end else if (to_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
               state_d = IDLE;
               busy_d  = 1'b0;
               hold_d  = 1'b0;
               error_d = 1'b1;
            end else begin
               to_d = to_q + 1'b1;
            end
`endif
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         hold_q  <= 1'b0;
         wdata_q <= '0;
         addr_q  <= '0;
         base_q  <= '0;
         count_q <= '0;
         acc_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         error_q <= 1'b0;
`ifdef LOAD_TIMEOUT_EN
         to_q    <= '0;
`endif
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         wdata_q <= wdata_d;
         addr_q  <= addr_d;
         base_q  <= base_d;
         count_q <= count_d;
         acc_q   <= acc_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         error_q <= error_d;
`ifdef LOAD_TIMEOUT_EN
         to_q    <= to_d;
`endif
      end
   end

endmodule

// File: tb/tb_image_load_ctrl.sv
// Randomized self-checking bench for image_load_ctrl using a small image geometry
// and a transaction-level model (accepted/written byte counts plus a data queue).
module tb_image_load_ctrl;

   localparam int W   = 16;
   localparam int H   = 4;
   localparam int BPP = 3;
   localparam int N   = 8;
   localparam int TO  = 16;
   localparam int BUF = W * H * BPP;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [3:0]  load_index = '0;
   logic [7:0]  byte_in = '0;
   logic        byte_valid = 1'b0;
   logic        mem_gnt = 1'b0;
   logic        byte_ready;
   logic        mem_req;
   logic [21:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        busy;
   logic        done;
   logic        error;
   logic [17:0] byte_count;

   image_load_ctrl #(
      .IMG_WIDTH(W), .IMG_HEIGHT(H), .BYTES_PER_PIXEL(BPP),
      .NUM_IMAGES(N), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .load_index(load_index),
      .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
      .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .busy(busy), .done(done), .error(error),
      .byte_count(byte_count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // Model: mode 0 = waiting for start, 1 = loading, 2 = completion cycle.
   int         m_mode = 0;
   int         m_acc = 0;
   int         m_cmp = 0;
   int         m_base = 0;
   int         m_idle = 0;
   bit         m_err = 1'b0;
   bit         m_valid = 1'b0;
   logic [7:0] m_q[$];

   int done_pulses = 0;
   int busy_cycles = 0;
   int first_addr = -1;
   int last_addr = -1;

   task automatic checkOutput(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input bit s, input logic [3:0] idx, input bit v, input bit g);
      start      = s;
      load_index = idx;
      byte_valid = v;
      byte_in    = 8'($urandom);
      mem_gnt    = g;
      @(posedge clk);
      #1;
   endtask

   // Compare the DUT against the model mid-cycle, then advance the model across the coming edge.
   always @(negedge clk) begin
      bit exp_ready, acc_now, cmp_now;
      exp_ready = (m_mode == 1) && ((m_acc == m_cmp) || mem_gnt) && (m_acc < BUF);
      if (m_valid) begin
         checkOutput("busy", busy, m_mode == 1);
         checkOutput("done", done, m_mode == 2);
         checkOutput("error", error, m_err);
         checkOutput("byte_count", byte_count, m_cmp);
         checkOutput("mem_req", mem_req, m_acc > m_cmp);
         checkOutput("byte_ready", byte_ready, exp_ready);
         if (m_acc > m_cmp && m_q.size() > 0) begin
            checkOutput("mem_addr", mem_addr, m_base + m_cmp);
            checkOutput("mem_wdata", mem_wdata, m_q[0]);
         end
      end
      if (done) done_pulses++;
      if (busy) busy_cycles++;
      if (mem_req && mem_gnt) begin
         if (byte_count == 0) first_addr = int'(mem_addr);
         last_addr = int'(mem_addr);
      end

      if (!rst) begin
         m_valid = 1'b1;
         m_mode = 0; m_acc = 0; m_cmp = 0; m_base = 0; m_idle = 0; m_err = 1'b0;
         m_q.delete();
      end else if (m_mode == 2) begin
         m_mode = 0;
      end else if (m_mode == 0) begin
         if (start) begin
            if (int'(load_index) < N) begin
               m_mode = 1; m_err = 1'b0; m_acc = 0; m_cmp = 0; m_idle = 0;
               m_base = int'(load_index) * BUF;
            end else begin
               m_err = 1'b1;
            end
         end
      end else begin
         acc_now = byte_valid && exp_ready;
         cmp_now = (m_acc > m_cmp) && mem_gnt;
         if (cmp_now) begin
            void'(m_q.pop_front());
            m_cmp++;
         end
         if (acc_now) begin
            m_q.push_back(byte_in);
            m_acc++;
            m_idle = 0;
         end else begin
            m_idle++;
         end
         if (cmp_now && m_cmp == BUF) begin
            m_mode = 2;
         end
`ifdef LOAD_TIMEOUT_EN
         else if (!acc_now && m_idle == TO) begin
            m_mode = 0; m_err = 1'b1; m_acc = m_cmp;
            m_q.delete();
         end
`endif
      end
   end

   initial begin
      int budget;

      // Reset for two cycles, then release.
      rst = 1'b0;
      applyStimulus(0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0);
      rst = 1'b1;
      applyStimulus(0, 0, 1, 1);
      checkOutput("rst_byte_ready", byte_ready, 0);
      checkOutput("rst_mem_req", mem_req, 0);
      checkOutput("rst_mem_addr", mem_addr, 0);
      checkOutput("rst_mem_wdata", mem_wdata, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_done", done, 0);
      checkOutput("rst_error", error, 0);
      checkOutput("rst_byte_count", byte_count, 0);

      // Full-rate load into slot 2.
      done_pulses = 0; busy_cycles = 0; first_addr = -1; last_addr = -1;
      applyStimulus(1, 2, 1, 1);
      budget = 0;
      while (done_pulses == 0 && budget < 400) begin
         applyStimulus(0, 2, 1, 1);
         budget++;
      end
      checkOutput("full_done_seen", done_pulses > 0, 1);
      repeat (4) applyStimulus(0, 0, 1, 1);
      checkOutput("full_first_addr", first_addr, 384);
      checkOutput("full_last_addr", last_addr, 575);
      checkOutput("full_done_pulses", done_pulses, 1);
      checkOutput("full_busy_cycles", busy_cycles, BUF + 1);
      checkOutput("full_byte_count", byte_count, 192);

      // Grant only one cycle in four, random valid, stray starts during the load.
      done_pulses = 0;
      applyStimulus(1, 5, 1, 0);
      budget = 0;
      while (done_pulses == 0 && budget < 3000) begin
         applyStimulus(($urandom_range(0, 7) == 0), 4'($urandom), ($urandom_range(0, 3) != 0),
                       (budget % 4 == 0));
         budget++;
      end
      checkOutput("stall_done_seen", done_pulses > 0, 1);
      applyStimulus(0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0);
      checkOutput("stall_done_pulses", done_pulses, 1);
      checkOutput("stall_byte_count", byte_count, 192);

      // Out-of-range slot sets error; a valid start clears it.
      applyStimulus(1, 15, 1, 1);
      applyStimulus(0, 0, 1, 1);
      checkOutput("bad_idx_error", error, 1);
      checkOutput("bad_idx_busy", busy, 0);
      checkOutput("bad_idx_ready", byte_ready, 0);
      applyStimulus(1, 1, 1, 1);
      checkOutput("recover_error", error, 0);
      checkOutput("recover_busy", busy, 1);
      done_pulses = 0;
      budget = 0;
      while (done_pulses == 0 && budget < 2000) begin
         applyStimulus(0, 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
         budget++;
      end
      checkOutput("recover_done_seen", done_pulses > 0, 1);

      // Reset in the middle of a load.
      applyStimulus(1, 3, 1, 1);
      budget = 0;
      while (m_acc < 100 && budget < 1000) begin
         applyStimulus(0, 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
         budget++;
      end
      checkOutput("midrst_reached_100", m_acc >= 100, 1);
      done_pulses = 0;
      rst = 1'b0;
      applyStimulus(0, 0, 1, 0);
      rst = 1'b1;
      checkOutput("midrst_mem_req", mem_req, 0);
      checkOutput("midrst_busy", busy, 0);
      checkOutput("midrst_done", done, 0);
      checkOutput("midrst_error", error, 0);
      checkOutput("midrst_byte_count", byte_count, 0);
      applyStimulus(0, 0, 0, 0);
      checkOutput("midrst_no_done", done_pulses, 0);

      // Stall the byte stream after ten accepted bytes.
      applyStimulus(1, 0, 1, 1);
      budget = 0;
      while (m_acc < 10 && budget < 100) begin
         applyStimulus(0, 0, 1, 1);
         budget++;
      end
      checkOutput("stall10_reached", m_acc, 10);
      done_pulses = 0;
      repeat (15) applyStimulus(0, 0, 0, 1);
      checkOutput("to_busy_before", busy, 1);
      applyStimulus(0, 0, 0, 1);
`ifdef LOAD_TIMEOUT_EN
      checkOutput("to_busy_after", busy, 0);
      checkOutput("to_error_after", error, 1);
`else
      checkOutput("noto_busy_after", busy, 1);
      checkOutput("noto_error_after", error, 0);
`endif
      repeat (10) applyStimulus(0, 0, 0, 1);
      checkOutput("to_no_done", done_pulses, 0);
`ifndef LOAD_TIMEOUT_EN
      checkOutput("noto_still_busy", busy, 1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
